// File: rtl/eth_ram_port_arbiter.sv
// Port-1 arbiter for the received-Ethernet-packet RAM.
// Shares the port between ecpri_rx (req 0) and ecpri_tx (req 1).
module eth_ram_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_HOLD   = 64,
    parameter int HOLD_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_0,
    input  logic                  req_1,
    input  logic [ADDR_WIDTH-1:0] addr_0,
    input  logic [DATA_WIDTH-1:0] wdata_0,
    input  logic                  we_0,
    input  logic                  oe_0,
    input  logic [ADDR_WIDTH-1:0] addr_1,
    input  logic [DATA_WIDTH-1:0] wdata_1,
    input  logic                  we_1,
    input  logic                  oe_1,
    output logic                  gnt_0,
    output logic                  gnt_1,
    output logic [DATA_WIDTH-1:0] rdata_0,
    output logic [DATA_WIDTH-1:0] rdata_1,
    output logic                  rvalid_0,
    output logic                  rvalid_1,
    output logic                  ram_cs,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_we,
    output logic                  ram_oe,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  preempt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;
    localparam logic [1:0] TURN = 2'd3;

    logic [1:0]        state;
    logic              last_owner;
    logic [HOLD_W-1:0] hold_cnt;
    logic              rd_vld;
    logic              rd_own;

    logic owning;
    logic owner;
    logic own_req;
    logic oth_req;
    logic hold_hit;

    assign owning  = (state == OWN0) || (state == OWN1);
    assign owner   = (state == OWN1);
    assign own_req = owner ? req_1 : req_0;
    assign oth_req = owner ? req_0 : req_1;

    // Sticky once the limit is reached, so a late waiter still forces release.
    assign hold_hit = (MAX_HOLD != 0) &&
                      (hold_cnt >= HOLD_W'(MAX_HOLD - 1));

    assign gnt_0 = (state == OWN0);
    assign gnt_1 = (state == OWN1);

    always_comb begin
        ram_cs    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        ram_oe    = 1'b0;
        if (owning) begin
            ram_cs    = 1'b1;
            ram_addr  = owner ? addr_1 : addr_0;
            ram_wdata = owner ? wdata_1 : wdata_0;
            ram_we    = owner ? we_1 : we_0;
            ram_oe    = owner ? (oe_1 & ~we_1) : (oe_0 & ~we_0);
        end
    end

    assign rdata_0  = ram_rdata;
    assign rdata_1  = ram_rdata;
    assign rvalid_0 = rd_vld & ~rd_own;
    assign rvalid_1 = rd_vld & rd_own;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            hold_cnt   <= '0;
            rd_vld     <= 1'b0;
            rd_own     <= 1'b0;
            preempt    <= 1'b0;
        end else begin
            preempt <= 1'b0;
            rd_vld  <= ram_cs & ram_oe;
            rd_own  <= owner;
            case (state)
                IDLE: begin
                    if (req_0 && (!req_1 || last_owner)) begin
                        state    <= OWN0;
                        hold_cnt <= '0;
                    end else if (req_1) begin
                        state    <= OWN1;
                        hold_cnt <= '0;
                    end
                end
                OWN0, OWN1: begin
                    if (hold_cnt != '1)
                        hold_cnt <= hold_cnt + 1'b1;
                    if (!own_req) begin
                        state      <= TURN;
                        last_owner <= owner;
                    end else if (hold_hit && oth_req) begin
                        state      <= TURN;
                        last_owner <= owner;
                        preempt    <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_ram_port_arbiter.sv
// Bench for eth_ram_port_arbiter: directed scenarios plus random traffic
// against an ownership/scoreboard model and a behavioural RAM.
module tb_eth_ram_port_arbiter;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int MH = 8;
    localparam int HW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_0, req_1;
    logic [AW-1:0] addr_0, addr_1;
    logic [DW-1:0] wdata_0, wdata_1;
    logic          we_0, oe_0, we_1, oe_1;
    logic          gnt_0, gnt_1;
    logic [DW-1:0] rdata_0, rdata_1;
    logic          rvalid_0, rvalid_1;
    logic          ram_cs;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we, ram_oe;
    logic [DW-1:0] ram_rdata;
    logic          preempt;

    always #5 clk = ~clk;

    eth_ram_port_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_HOLD(MH), .HOLD_W(HW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_0(req_0), .req_1(req_1),
        .addr_0(addr_0), .wdata_0(wdata_0), .we_0(we_0), .oe_0(oe_0),
        .addr_1(addr_1), .wdata_1(wdata_1), .we_1(we_1), .oe_1(oe_1),
        .gnt_0(gnt_0), .gnt_1(gnt_1),
        .rdata_0(rdata_0), .rdata_1(rdata_1),
        .rvalid_0(rvalid_0), .rvalid_1(rvalid_1),
        .ram_cs(ram_cs), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_oe(ram_oe), .ram_rdata(ram_rdata),
        .preempt(preempt)
    );

    logic [DW-1:0] ram     [0:255];
    logic [DW-1:0] ref_mem [0:255];

    always @(posedge clk) begin
        if (ram_cs && ram_we) ram[ram_addr[7:0]] <= ram_wdata;
        if (ram_cs && ram_oe) ram_rdata <= ram[ram_addr[7:0]];
    end

    int n_chk = 0;
    int n_fail = 0;

    // model: who owns, turnaround pending, cycles held, pending read tag
    int            m_own, m_last, m_held, m_rtag;
    bit            m_turn, m_pre;
    logic [DW-1:0] m_rdat;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    int            n_pre;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_own  = -1;
        m_last = 1;
        m_held = 0;
        m_rtag = -1;
        m_turn = 0;
        m_pre  = 0;
        m_rdat = '0;
    endtask

    task automatic drive_idle();
        req_0 = 0; req_1 = 0;
        we_0 = 0; oe_0 = 0; we_1 = 0; oe_1 = 0;
        addr_0 = '0; addr_1 = '0; wdata_0 = '0; wdata_1 = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic cycle(input bit r0, input bit r1,
                         input bit w0, input bit o0,
                         input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input bit w1, input bit o1,
                         input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        bit            ewe, eoe, ocur, oth;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        int            nt;
        @(negedge clk);
        req_0 = r0; req_1 = r1;
        we_0 = w0; oe_0 = o0; addr_0 = a0; wdata_0 = d0;
        we_1 = w1; oe_1 = o1; addr_1 = a1; wdata_1 = d1;
        #1;
        ewe = 0; eoe = 0; ea = '0; ed = '0;
        if (m_own == 0) begin
            ewe = w0; eoe = o0 & ~w0; ea = a0; ed = d0;
        end else if (m_own == 1) begin
            ewe = w1; eoe = o1 & ~w1; ea = a1; ed = d1;
        end
        check("gnt_0", gnt_0, m_own == 0);
        check("gnt_1", gnt_1, m_own == 1);
        check("excl", gnt_0 & gnt_1, 0);
        check("ram_cs", ram_cs, m_own >= 0);
        check("ram_we", ram_we, ewe);
        check("ram_oe", ram_oe, eoe);
        check("ram_addr", ram_addr, ea);
        check("ram_wdata", ram_wdata, ed);
        check("preempt", preempt, m_pre);
        check("rvalid_0", rvalid_0, m_rtag == 0);
        check("rvalid_1", rvalid_1, m_rtag == 1);
        if (m_rtag == 0) check("rdata_0", rdata_0, m_rdat);
        if (m_rtag == 1) check("rdata_1", rdata_1, m_rdat);
        if (rvalid_0) q0.push_back(rdata_0);
        if (rvalid_1) q1.push_back(rdata_1);
        if (preempt) n_pre++;
        // what the coming edge does
        nt = -1;
        if (eoe) begin
            nt = m_own;
            m_rdat = ref_mem[ea[7:0]];
        end
        if (ewe) ref_mem[ea[7:0]] = ed;
        m_rtag = nt;
        m_pre = 0;
        if (m_turn) begin
            m_turn = 0;
        end else if (m_own >= 0) begin
            m_held++;
            ocur = (m_own == 0) ? r0 : r1;
            oth  = (m_own == 0) ? r1 : r0;
            if (!ocur || (m_held >= MH && oth)) begin
                m_pre  = ocur;
                m_last = m_own;
                m_own  = -1;
                m_turn = 1;
            end
        end else if (r0 && r1) begin
            m_own = (m_last == 0) ? 1 : 0;
            m_held = 0;
        end else if (r0 || r1) begin
            m_own = r0 ? 0 : 1;
            m_held = 0;
        end
    endtask

    task automatic req_only(input bit r0, input bit r1);
        cycle(r0, r1, 0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    initial begin
        bit          s0, s1;
        int          rv0;
        logic [DW-1:0] exp6;
        reset = 1'b1;
        drive_idle();
        for (int i = 0; i < 256; i++) begin
            ram[i]     = DW'(i * 7 + 3);
            ref_mem[i] = DW'(i * 7 + 3);
        end
        for (int i = 0; i < 4; i++) begin
            ram[i]     = DW'(8'h11 + i);
            ref_mem[i] = DW'(8'h11 + i);
        end
        model_reset();
        do_reset();

        // four back-to-back reads by requester 0
        q0.delete(); q1.delete();
        req_only(1, 0);
        for (int i = 0; i < 4; i++)
            cycle(1, 0, 0, 1, AW'(i), '0, 0, 0, '0, '0);
        req_only(0, 0);
        repeat (3) req_only(0, 0);
        check("s1_n_rv0", q0.size(), 4);
        check("s1_n_rv1", q1.size(), 0);
        for (int i = 0; i < 4 && i < q0.size(); i++)
            check("s1_rdata", q0[i], 8'h11 + i);

        // tie after reset, then handoff through TURN
        do_reset();
        req_only(1, 1);
        check("s2_first_gnt0", gnt_0, 0);
        repeat (3) req_only(1, 1);
        req_only(0, 1);
        repeat (4) req_only(0, 1);
        req_only(0, 0);
        repeat (3) req_only(0, 0);

        // forced preemption after MH owned cycles
        do_reset();
        n_pre = 0;
        req_only(1, 0);
        repeat (12) req_only(1, 1);
        repeat (3) req_only(1, 0);
        repeat (4) req_only(1, 0);
        req_only(0, 0);
        repeat (3) req_only(0, 0);
        check("s3_n_preempt", n_pre, 1);

        // write wins over simultaneous read, then read back
        do_reset();
        q0.delete();
        req_only(1, 0);
        cycle(1, 0, 1, 1, 16'h0010, 8'hA5, 0, 0, '0, '0);
        cycle(1, 0, 0, 0, '0, '0, 0, 0, '0, '0);
        cycle(1, 0, 0, 1, 16'h0010, '0, 0, 0, '0, '0);
        req_only(0, 0);
        repeat (2) req_only(0, 0);
        check("s4_n_rv0", q0.size(), 1);
        if (q0.size() > 0) check("s4_rd_a5", q0[0], 8'hA5);
        check("s4_ram", ram[16], 8'hA5);

        // reset mid-burst with a read in flight
        do_reset();
        req_only(1, 0);
        cycle(1, 0, 0, 1, 16'h0002, '0, 0, 0, '0, '0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("s5_gnt_0", gnt_0, 0);
        check("s5_ram_cs", ram_cs, 0);
        check("s5_ram_oe", ram_oe, 0);
        check("s5_rvalid_0", rvalid_0, 0);
        check("s5_preempt", preempt, 0);
        @(negedge clk);
        drive_idle();
        reset = 1'b1;
        model_reset();
        req_only(1, 1);
        req_only(1, 1);
        check("s5_tie_gnt0", gnt_0, 1);
        req_only(0, 0);
        repeat (3) req_only(0, 0);

        // read on requester 1's final owned cycle returns during TURN
        do_reset();
        q0.delete(); q1.delete();
        exp6 = ref_mem[6];
        req_only(0, 1);
        cycle(0, 1, 0, 0, '0, '0, 0, 1, 16'h0005, '0);
        cycle(0, 0, 0, 0, '0, '0, 0, 1, 16'h0006, '0);
        rv0 = q0.size();
        req_only(0, 0);
        check("s6_turn_rv1", rvalid_1 & ~gnt_1, 1);
        req_only(0, 0);
        check("s6_n_rv1", q1.size(), 2);
        if (q1.size() == 2) check("s6_rdata", q1[1], exp6);
        check("s6_n_rv0", q0.size(), rv0);

        // random traffic
        do_reset();
        s0 = 0; s1 = 0;
        for (int c = 0; c < 600; c++) begin
            if (s0 && m_own == 0 && $urandom_range(5) == 0) s0 = 0;
            else if (!s0 && $urandom_range(3) == 0) s0 = 1;
            if (s1 && m_own == 1 && $urandom_range(5) == 0) s1 = 0;
            else if (!s1 && $urandom_range(3) == 0) s1 = 1;
            cycle(s0, s1,
                  $urandom_range(3) == 0, $urandom_range(1) == 0,
                  AW'($urandom_range(31)), DW'($urandom),
                  $urandom_range(3) == 0, $urandom_range(1) == 0,
                  AW'($urandom_range(31)), DW'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
